// File: rtl/burst_cas.sv
// ---------------------------------------------------------------------------
// burst_cas -- column-command (CAS) sequencer
//
// Sits directly behind the ACT/PRECHARGE sequencer. It takes one request per
// activated (act_rdy) or already-open (act_hit) row. Before it issues the
// READ/WRITE command it enforces tRCD, tCCD and the read/write turnaround.
// It then follows the data burst of every issued CAS so that the ACT stage
// can time PRECHARGE from cas_rdy, cas_idle and rw_request.
//
// Optional feature: define CAS_AUTO_PRE_EN to add the auto_pre input and the
// cas_ap output. In that build an auto-precharge CAS keeps cas_idle low until
// its burst has ended plus TRP further cycles.
//
// Ports
//   clock_t      in   1      main clock
//   reset        in   1      asynchronous active-high reset
//   act_rdy      in   1      pulse: ACT issued, the request must wait tRCD
//   act_hit      in   1      pulse: row already open, the request skips tRCD
//   rw_in        in   2      request type (READ=01, WRITE=10)
//   col_in       in   COL_W  column address of the request
//   auto_pre     in   1      (CAS_AUTO_PRE_EN only) request auto-precharge
//   cas_ap       out  1      (CAS_AUTO_PRE_EN only) auto-precharge, with cas_rdy
//   req_ready    out  1      pending slot empty
//   cas_rdy      out  1      pulse: issue CAS this cycle
//   cas_cmd      out  2      READ/WRITE code, valid with cas_rdy
//   cas_col      out  COL_W  column address, valid with cas_rdy
//   rw_request   out  2      direction of the most recent CAS
//   data_start   out  1      pulse on the first data cycle of a burst
//   data_busy    out  1      high for every data cycle of a burst
//   cas_idle     out  1      nothing pending, scheduled or on the data bus
//   req_overflow out  1      sticky: a request arrived while req_ready=0
// ---------------------------------------------------------------------------
module burst_cas #(
    parameter int TRCD  = 15,
    parameter int TCCD  = 4,
    parameter int CL    = 11,
    parameter int CWL   = 9,
    parameter int AL    = 0,
    parameter int BL    = 8,
    parameter int TWTR  = 6,
    parameter int COL_W = 10
`ifdef CAS_AUTO_PRE_EN
    ,
    parameter int TRP   = 11
`endif
) (
    input  logic             clock_t,
    input  logic             reset,
    input  logic             act_rdy,
    input  logic             act_hit,
    input  logic [1:0]       rw_in,
    input  logic [COL_W-1:0] col_in,
`ifdef CAS_AUTO_PRE_EN
    input  logic             auto_pre,
    output logic             cas_ap,
`endif
    output logic             req_ready,
    output logic             cas_rdy,
    output logic [1:0]       cas_cmd,
    output logic [COL_W-1:0] cas_col,
    output logic [1:0]       rw_request,
    output logic             data_start,
    output logic             data_busy,
    output logic             cas_idle,
    output logic             req_overflow
);

    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    localparam logic [1:0] CAS_IDLE      = 2'd0;
    localparam logic [1:0] CAS_TRCD_WAIT = 2'd1;
    localparam logic [1:0] CAS_GAP_WAIT  = 2'd2;
    localparam logic [1:0] CAS_ISSUE     = 2'd3;

    localparam int RL      = AL + CL;
    localparam int WL      = AL + CWL;
    localparam int DEPTH   = AL + ((CL > CWL) ? CL : CWL) + 1;
    localparam int BURST   = BL / 2;
    // CAS-to-CAS distance needed when the direction changes
    localparam int WTR_GAP = AL + CWL + BURST + TWTR;
    localparam int RTW_GAP = CL + BURST + 2 - CWL;

    // A counter loaded with N-1 on the issue edge reaches 0 exactly N cycles
    // after the CAS cycle.
    localparam logic [7:0] TRCD_LOAD  = 8'(TRCD - 1);
    localparam logic [7:0] CCD_LOAD   = 8'(TCCD - 1);
    localparam logic [7:0] WTR_LOAD   = 8'(WTR_GAP - 1);
    localparam logic [7:0] RTW_LOAD   = (RTW_GAP > 1) ? 8'(RTW_GAP - 1) : 8'd0;
    localparam logic [7:0] BURST_LOAD = 8'(BURST - 1);

    function automatic logic [7:0] dec_sat(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [7:0]       trcd_cnt_q, trcd_cnt_d;
    logic [7:0]       ccd_cnt_q, ccd_cnt_d;
    logic [7:0]       turn_cnt_q, turn_cnt_d;
    logic [7:0]       busy_cnt_q, busy_cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [1:0]       pend_rw_q, pend_rw_d;
    logic [COL_W-1:0] pend_col_q, pend_col_d;
    logic [1:0]       rw_req_q, rw_req_d;
    logic             ovf_q, ovf_d;
    logic [DEPTH-1:0] pipe_v_q, pipe_v_d;
    logic [DEPTH-1:0] pipe_w_q, pipe_w_d;

    logic             req_in;
    logic             capture;
    logic             gap_ok;
    logic [1:0]       state_cur;
    logic             issue;
    logic [DEPTH-1:0] fire;
    logic             ap_idle;

    assign req_in  = act_rdy | act_hit;
    assign capture = req_in & ~pend_valid_q;

    // A wait state whose exit condition already holds costs no cycle. The
    // registered state is therefore resolved here through TRCD_WAIT ->
    // GAP_WAIT -> ISSUE. This lets a hit request issue on the cycle that
    // follows its capture.
    always_comb begin
        gap_ok = (ccd_cnt_q == 8'd0) &&
                 ((turn_cnt_q == 8'd0) || (pend_rw_q == rw_req_q));
        state_cur = state_q;
        if ((state_cur == CAS_TRCD_WAIT) && (trcd_cnt_q == 8'd0)) begin
            state_cur = CAS_GAP_WAIT;
        end
        if ((state_cur == CAS_GAP_WAIT) && gap_ok) begin
            state_cur = CAS_ISSUE;
        end
        issue = (state_cur == CAS_ISSUE);
    end

    // A pipeline slot fires data_start when its entry reaches the latency of
    // its own direction. The entry is then dropped, so an empty pipeline
    // means that no burst is still waiting to start.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fire
        assign fire[gi] = pipe_v_q[gi] &
                          (pipe_w_q[gi] ? (gi == WL - 1) : (gi == RL - 1));
    end

    assign data_start = |fire;
    assign data_busy  = data_start | (busy_cnt_q != 8'd0);

    always_comb begin
        state_d      = state_q;
        trcd_cnt_d   = dec_sat(trcd_cnt_q);
        ccd_cnt_d    = dec_sat(ccd_cnt_q);
        turn_cnt_d   = dec_sat(turn_cnt_q);
        busy_cnt_d   = dec_sat(busy_cnt_q);
        pend_valid_d = pend_valid_q;
        pend_rw_d    = pend_rw_q;
        pend_col_d   = pend_col_q;
        rw_req_d     = rw_req_q;
        ovf_d        = ovf_q | (req_in & pend_valid_q);
        pipe_v_d     = '0;
        pipe_w_d     = '0;

        case (state_cur)
            CAS_IDLE:      if (capture) state_d = CAS_TRCD_WAIT;
            CAS_TRCD_WAIT: state_d = CAS_TRCD_WAIT;
            CAS_GAP_WAIT:  state_d = CAS_GAP_WAIT;
            default:       state_d = CAS_IDLE;
        endcase

        if (capture) begin
            pend_valid_d = 1'b1;
            pend_rw_d    = rw_in;
            pend_col_d   = col_in;
            // a simultaneous act_rdy/act_hit counts as a hit
            trcd_cnt_d   = act_hit ? 8'd0 : TRCD_LOAD;
        end

        if (issue) begin
            pend_valid_d = 1'b0;
            rw_req_d     = pend_rw_q;
            ccd_cnt_d    = CCD_LOAD;
            // Guards the opposite direction only. Same-direction CAS
            // commands bypass it (see gap_ok).
            turn_cnt_d   = (pend_rw_q == RW_WRITE) ? WTR_LOAD : RTW_LOAD;
        end

        if (data_start) begin
            busy_cnt_d = BURST_LOAD;
        end

        pipe_v_d[0] = issue;
        pipe_w_d[0] = issue & (pend_rw_q == RW_WRITE);
        for (int i = 1; i < DEPTH; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1] & ~fire[i-1];
            pipe_w_d[i] = pipe_w_q[i-1] & ~fire[i-1];
        end
    end

    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            state_q      <= CAS_IDLE;
            trcd_cnt_q   <= 8'd0;
            ccd_cnt_q    <= 8'd0;
            turn_cnt_q   <= 8'd0;
            busy_cnt_q   <= 8'd0;
            pend_valid_q <= 1'b0;
            pend_rw_q    <= 2'b00;
            pend_col_q   <= '0;
            rw_req_q     <= 2'b00;
            ovf_q        <= 1'b0;
            pipe_v_q     <= '0;
            pipe_w_q     <= '0;
        end else begin
            state_q      <= state_d;
            trcd_cnt_q   <= trcd_cnt_d;
            ccd_cnt_q    <= ccd_cnt_d;
            turn_cnt_q   <= turn_cnt_d;
            busy_cnt_q   <= busy_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_rw_q    <= pend_rw_d;
            pend_col_q   <= pend_col_d;
            rw_req_q     <= rw_req_d;
            ovf_q        <= ovf_d;
            pipe_v_q     <= pipe_v_d;
            pipe_w_q     <= pipe_w_d;
        end
    end

`ifdef CAS_AUTO_PRE_EN
    // ------------------------------------------------------------------
    // Auto-precharge: ap_arm is set by an auto-precharge CAS and holds until
    // the data bus has drained. ap_cnt then covers the tRP window.
    // ------------------------------------------------------------------
    localparam logic [7:0] TRP_LOAD = (TRP > 0) ? 8'(TRP - 1) : 8'd0;

    logic       pend_ap_q, pend_ap_d;
    logic       ap_arm_q, ap_arm_d;
    logic [7:0] ap_cnt_q, ap_cnt_d;

    always_comb begin
        pend_ap_d = pend_ap_q;
        ap_arm_d  = ap_arm_q;
        ap_cnt_d  = dec_sat(ap_cnt_q);
        if (capture) begin
            pend_ap_d = auto_pre;
        end else if (issue) begin
            pend_ap_d = 1'b0;
        end
        if (issue && pend_ap_q) begin
            ap_arm_d = 1'b1;
        end else if (ap_arm_q && (pipe_v_q == '0) && !data_busy) begin
            ap_arm_d = 1'b0;
            ap_cnt_d = TRP_LOAD;
        end
    end

    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            pend_ap_q <= 1'b0;
            ap_arm_q  <= 1'b0;
            ap_cnt_q  <= 8'd0;
        end else begin
            pend_ap_q <= pend_ap_d;
            ap_arm_q  <= ap_arm_d;
            ap_cnt_q  <= ap_cnt_d;
        end
    end

    assign cas_ap  = issue & pend_ap_q;
    assign ap_idle = ~ap_arm_q & (ap_cnt_q == 8'd0);
`else
    assign ap_idle = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready    = ~pend_valid_q;
    assign cas_rdy      = issue;
    assign cas_cmd      = issue ? pend_rw_q : 2'b00;
    assign cas_col      = issue ? pend_col_q : '0;
    assign rw_request   = rw_req_q;
    assign req_overflow = ovf_q;
    assign cas_idle     = (state_q == CAS_IDLE) & ~pend_valid_q &
                          (pipe_v_q == '0) & ~data_busy & ap_idle;

endmodule

// File: tb/tb_burst_cas.sv
`timescale 1ns/1ps
module tb_burst_cas;
    localparam int TRCD  = 15;
    localparam int TCCD  = 4;
    localparam int CL    = 11;
    localparam int CWL   = 9;
    localparam int AL    = 0;
    localparam int BL    = 8;
    localparam int TWTR  = 6;
    localparam int COL_W = 10;
    localparam int BURST = BL / 2;
    localparam int MAXC  = 2048;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;

    logic             clock_t = 1'b0;
    logic             reset   = 1'b1;
    logic             act_rdy = 1'b0;
    logic             act_hit = 1'b0;
    logic [1:0]       rw_in   = 2'b00;
    logic [COL_W-1:0] col_in  = '0;
    logic             req_ready, cas_rdy, data_start, data_busy, cas_idle, req_overflow;
    logic [1:0]       cas_cmd, rw_request;
    logic [COL_W-1:0] cas_col;

    burst_cas dut (
        .clock_t(clock_t), .reset(reset), .act_rdy(act_rdy), .act_hit(act_hit),
        .rw_in(rw_in), .col_in(col_in), .req_ready(req_ready), .cas_rdy(cas_rdy),
        .cas_cmd(cas_cmd), .cas_col(cas_col), .rw_request(rw_request),
        .data_start(data_start), .data_busy(data_busy), .cas_idle(cas_idle),
        .req_overflow(req_overflow)
    );

    always #5 clock_t = ~clock_t;

    int cyc = 0;
    always @(posedge clock_t) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------
    // Scoreboard / reference model
    // ---------------------------------------------------------------
    typedef struct {
        int               cyc;
        logic [1:0]       cmd;
        logic [COL_W-1:0] col;
    } cas_exp_t;

    cas_exp_t q_cas[$];
    int       q_ds[$];

    bit       notready[MAXC];
    bit       nonidle[MAXC];
    bit       busy[MAXC];
    bit [1:0] exp_rw[MAXC];
    int       ovf_from   = MAXC + 10;
    int       m_pend_cap = -10;
    int       m_pend_cas = -10;
    int       m_last_cas = -1000;
    bit [1:0] m_last_dir = 2'b00;
    int       m_idle_end = 0;

    // mode: 0 = act_rdy only, 1 = act_hit only, 2 = both (counts as a hit)
    task automatic send_req(input int mode, input logic [1:0] rw, input logic [COL_W-1:0] col);
        int k, e, ds, gap;
        bit hit;
        k   = cyc;
        hit = (mode != 0);
        if (!(k > m_pend_cap && k <= m_pend_cas)) begin
            e = k + (hit ? 1 : TRCD);
            if (m_last_cas + TCCD > e) e = m_last_cas + TCCD;
            if (m_last_dir != 2'b00 && m_last_dir != rw) begin
                gap = (m_last_dir == WR) ? (AL + CWL + BURST + TWTR) : (CL + BURST + 2 - CWL);
                if (m_last_cas + gap > e) e = m_last_cas + gap;
            end
            ds = e + ((rw == WR) ? (AL + CWL) : (AL + CL));
            q_cas.push_back('{e, rw, col});
            q_ds.push_back(ds);
            for (int c = k + 1; c <= e && c < MAXC; c++) notready[c] = 1'b1;
            for (int c = k + 1; c <= ds + BURST - 1 && c < MAXC; c++) nonidle[c] = 1'b1;
            for (int c = ds; c <= ds + BURST - 1 && c < MAXC; c++) busy[c] = 1'b1;
            for (int c = e + 1; c < MAXC; c++) exp_rw[c] = rw;
            m_pend_cap = k;
            m_pend_cas = e;
            m_last_cas = e;
            m_last_dir = rw;
            if (ds + BURST - 1 > m_idle_end) m_idle_end = ds + BURST - 1;
        end else if (ovf_from > k + 1) begin
            ovf_from = k + 1;
        end
        act_rdy = (mode != 1);
        act_hit = (mode != 0);
        rw_in   = rw;
        col_in  = col;
        @(posedge clock_t);
        #1;
        act_rdy = 1'b0;
        act_hit = 1'b0;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clock_t);
            #1;
        end
    endtask

    task automatic model_reset(input int from);
        for (int c = from; c < MAXC; c++) begin
            notready[c] = 1'b0;
            nonidle[c]  = 1'b0;
            busy[c]     = 1'b0;
            exp_rw[c]   = 2'b00;
        end
        q_cas.delete();
        q_ds.delete();
        ovf_from   = MAXC + 10;
        m_pend_cap = -10;
        m_pend_cas = -10;
        m_last_cas = -1000;
        m_last_dir = 2'b00;
    endtask

    // ---------------------------------------------------------------
    // Monitor: samples on the falling edge
    // ---------------------------------------------------------------
    always @(negedge clock_t) begin
        int c;
        cas_exp_t ec;
        int ds;
        c = cyc;
        if (c < MAXC) begin
            check_eq("req_ready", req_ready, !notready[c]);
            check_eq("cas_idle", cas_idle, !nonidle[c]);
            check_eq("data_busy", data_busy, busy[c]);
            check_eq("rw_request", rw_request, exp_rw[c]);
            check_eq("req_overflow", req_overflow, (c >= ovf_from));
        end
        if (q_cas.size() != 0 && q_cas[0].cyc == c) begin
            ec = q_cas.pop_front();
            check_eq("cas_rdy", cas_rdy, 1);
            check_eq("cas_cmd", cas_cmd, ec.cmd);
            check_eq("cas_col", cas_col, ec.col);
        end else begin
            check_eq("cas_rdy_quiet", cas_rdy, 0);
        end
        if (q_ds.size() != 0 && q_ds[0] == c) begin
            ds = q_ds.pop_front();
            check_eq("data_start", data_start, 1);
        end else begin
            check_eq("data_start_quiet", data_start, 0);
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin
        int b, g, r, mode;
        logic [1:0] rw;

        #12;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_cas_idle", cas_idle, 1);
        check_eq("rst_cas_rdy", cas_rdy, 0);
        check_eq("rst_rw_request", rw_request, 0);
        check_eq("rst_req_overflow", req_overflow, 0);
        check_eq("rst_data_busy", data_busy, 0);
        #10 reset = 1'b0;
        @(posedge clock_t);
        #1;
        b = cyc;

        // ACT READ: CAS after tRCD, data after CL
        at_cycle(b + 10);
        send_req(0, RD, 10'h03A);

        // hit WRITE, then hit READ held off by write-to-read turnaround
        at_cycle(b + 55);
        send_req(1, WR, 10'h155);
        at_cycle(b + 57);
        send_req(1, RD, 10'h0F0);

        // back-to-back hit READs at tCCD: continuous data_busy
        at_cycle(b + 105);
        send_req(1, RD, 10'h001);
        at_cycle(b + 107);
        send_req(1, RD, 10'h3FF);

        // ACT READ with a second request dropped as overflow
        at_cycle(b + 145);
        send_req(0, RD, 10'h2AA);
        at_cycle(b + 148);
        send_req(0, WR, 10'h111);

        // read-to-write turnaround; both strobes set counts as a hit
        at_cycle(b + 190);
        send_req(1, RD, 10'h080);
        at_cycle(b + 192);
        send_req(2, WR, 10'h040);

        // random mix
        at_cycle(b + 220);
        for (int i = 0; i < 24; i++) begin
            r    = $urandom_range(0, 18);
            mode = $urandom_range(0, 2);
            rw   = ($urandom_range(0, 1) == 0) ? RD : WR;
            at_cycle(cyc + r);
            send_req(mode, rw, COL_W'($urandom));
        end
        at_cycle(m_idle_end + 3);

        // reset two cycles after a CAS: the burst must never start
        g = cyc;
        send_req(1, RD, 10'h2C3);
        at_cycle(g + 3);
        #1;
        reset = 1'b1;
        model_reset(cyc);
        #1;
        check_eq("mid_rst_req_ready", req_ready, 1);
        check_eq("mid_rst_cas_idle", cas_idle, 1);
        check_eq("mid_rst_data_busy", data_busy, 0);
        check_eq("mid_rst_req_overflow", req_overflow, 0);
        @(posedge clock_t);
        #2;
        reset = 1'b0;
        #1;
        at_cycle(cyc + 20);

        // recovery after reset
        send_req(1, WR, 10'h0AB);
        at_cycle(m_idle_end + 5);

        check_eq("cas_queue_drained", q_cas.size(), 0);
        check_eq("ds_queue_drained", q_ds.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
